// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: pipeline/CSR-file signals exchanged with the trap initiator
interface trap_ctrl_if;
  logic        MEM_WAIT;
  logic        EXC_EN;
  logic [31:0] EXC_CODE;
  logic [31:0] EXC_PC;
  logic        INT_EXT;
  logic        INT_SOFT;
  logic        INT_TIMER;
  logic [31:0] INT_PC;
  logic        INT_ALLOW;
  logic [1:0]  TRAP_VEC_MODE;
  logic [31:0] TRAP_VEC_BASE;
  logic        TRAP_EN;
  logic [31:0] TRAP_CODE;
  logic [31:0] TRAP_PC;
  logic        FLUSH;
  logic [31:0] NEW_PC;
  logic        BUSY;
  modport slave (
    input  MEM_WAIT, EXC_EN, EXC_CODE, EXC_PC, INT_EXT, INT_SOFT, INT_TIMER, INT_PC,
           INT_ALLOW, TRAP_VEC_MODE, TRAP_VEC_BASE,
    output TRAP_EN, TRAP_CODE, TRAP_PC, FLUSH, NEW_PC, BUSY
  );
  modport master (
    output MEM_WAIT, EXC_EN, EXC_CODE, EXC_PC, INT_EXT, INT_SOFT, INT_TIMER, INT_PC,
           INT_ALLOW, TRAP_VEC_MODE, TRAP_VEC_BASE,
    input  TRAP_EN, TRAP_CODE, TRAP_PC, FLUSH, NEW_PC, BUSY
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: arbitrates exceptions vs interrupts and sequences trap entry (wait mem, commit, redirect)
module trap_ctrl #(
  parameter bit EXC_PRIO_FIRST = 1'b1
) (
  input logic        CLK,
  input logic        RST,
  trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT, REDIRECT} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_code, r_pc, r_tgt, r_trap_code, r_trap_pc, r_new_pc;
  logic        w_int_req, w_pick_int, w_req;
  logic [31:0] w_int_code, w_code, w_pc, w_tgt;
  assign w_int_req  = bus.INT_ALLOW & (bus.INT_EXT | bus.INT_SOFT | bus.INT_TIMER);
  assign w_int_code = bus.INT_EXT ? 32'h8000_000B : bus.INT_SOFT ? 32'h8000_0003 : 32'h8000_0007;
  // the losing exception is simply dropped; a losing interrupt stays asserted and is re-sampled
  assign w_pick_int = w_int_req & (~bus.EXC_EN | ~EXC_PRIO_FIRST);
  assign w_req      = bus.EXC_EN | w_int_req;
  assign w_code     = w_pick_int ? w_int_code : {1'b0, bus.EXC_CODE[30:0]};
  assign w_pc       = w_pick_int ? bus.INT_PC : bus.EXC_PC;
  assign w_tgt      = (w_pick_int && bus.TRAP_VEC_MODE == 2'b01)
                      ? bus.TRAP_VEC_BASE + {25'd0, w_code[4:0], 2'b00} : bus.TRAP_VEC_BASE;
  assign bus.TRAP_CODE = r_trap_code;
  assign bus.TRAP_PC   = r_trap_pc;
  assign bus.NEW_PC    = r_new_pc;
  // state register; reset abandons any in-flight trap
  always_ff @(posedge CLK) r_state <= RST ? IDLE : w_next;
  // next-state: memory must be quiet before commit, then one cycle each of commit and redirect
  always_comb begin
    w_next = (r_state == IDLE)     ? (w_req ? (bus.MEM_WAIT ? WAIT_MEM : COMMIT) : IDLE) :
             (r_state == WAIT_MEM) ? (bus.MEM_WAIT ? WAIT_MEM : COMMIT) :
             (r_state == COMMIT)   ? REDIRECT : IDLE;
  end
  // strobes and stall decoded from state
  always_comb begin
    bus.TRAP_EN = r_state == COMMIT;
    bus.FLUSH   = r_state == REDIRECT;
    bus.BUSY    = r_state != IDLE;
  end
  // capture request (incl. mtvec snapshot) in IDLE; outputs load only when their phase begins
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_code      <= '0;
      r_pc        <= '0;
      r_tgt       <= '0;
      r_trap_code <= '0;
      r_trap_pc   <= '0;
      r_new_pc    <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_code <= w_code;
        r_pc   <= w_pc;
        r_tgt  <= w_tgt;
      end
      if (w_next == COMMIT) begin
        r_trap_code <= (r_state == IDLE) ? w_code : r_code;
        r_trap_pc   <= (r_state == IDLE) ? w_pc : r_pc;
      end
      if (r_state == COMMIT) r_new_pc <= r_tgt;
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and random checks of both arbitration polarities against a trap-level model
module tb_trap_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  trap_ctrl_if ia();
  trap_ctrl_if ib();
  always #5 CLK = ~CLK;
  assign ib.MEM_WAIT      = ia.MEM_WAIT;
  assign ib.EXC_EN        = ia.EXC_EN;
  assign ib.EXC_CODE      = ia.EXC_CODE;
  assign ib.EXC_PC        = ia.EXC_PC;
  assign ib.INT_EXT       = ia.INT_EXT;
  assign ib.INT_SOFT      = ia.INT_SOFT;
  assign ib.INT_TIMER     = ia.INT_TIMER;
  assign ib.INT_PC        = ia.INT_PC;
  assign ib.INT_ALLOW     = ia.INT_ALLOW;
  assign ib.TRAP_VEC_MODE = ia.TRAP_VEC_MODE;
  assign ib.TRAP_VEC_BASE = ia.TRAP_VEC_BASE;
  trap_ctrl #(.EXC_PRIO_FIRST(1'b1)) dut_a (.CLK(CLK), .RST(RST), .bus(ia.slave));
  trap_ctrl #(.EXC_PRIO_FIRST(1'b0)) dut_b (.CLK(CLK), .RST(RST), .bus(ib.slave));
  // model: one pending trap per instance; phase -1 = memory busy, 0 = commit visible, 1 = flush visible
  bit          m_pend[2];
  int          m_phase[2];
  logic [31:0] m_code[2], m_pc[2], m_tgt[2], e_code[2], e_pc[2], e_npc[2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void pick(input bit prio, output bit req, output logic [31:0] code,
                               output logic [31:0] pc, output logic [31:0] tgt);
    int cause;
    bit int_on, take_int;
    int_on   = ia.INT_ALLOW && (ia.INT_EXT || ia.INT_SOFT || ia.INT_TIMER);
    take_int = int_on && (!ia.EXC_EN || !prio);
    req      = int_on || ia.EXC_EN;
    cause    = ia.INT_EXT ? 11 : ia.INT_SOFT ? 3 : 7;
    if (take_int) begin
      code = 32'h8000_0000 + cause;
      pc   = ia.INT_PC;
      tgt  = ia.TRAP_VEC_BASE + ((ia.TRAP_VEC_MODE == 2'd1) ? 32'(cause * 4) : 32'd0);
    end else begin
      code = ia.EXC_CODE & 32'h7FFF_FFFF;
      pc   = ia.EXC_PC;
      tgt  = ia.TRAP_VEC_BASE;
    end
  endfunction
  task automatic cyc();
    for (int k = 0; k < 2; k++) begin
      bit req;
      logic [31:0] c, p, t;
      pick(k == 0, req, c, p, t);
      if (RST) begin
        m_pend[k] = 0; m_phase[k] = 0; e_code[k] = 0; e_pc[k] = 0; e_npc[k] = 0;
      end else if (!m_pend[k]) begin
        if (req) begin
          m_pend[k] = 1; m_code[k] = c; m_pc[k] = p; m_tgt[k] = t;
          m_phase[k] = ia.MEM_WAIT ? -1 : 0;
          if (!ia.MEM_WAIT) begin e_code[k] = c; e_pc[k] = p; end
        end
      end else if (m_phase[k] == -1) begin
        if (!ia.MEM_WAIT) begin m_phase[k] = 0; e_code[k] = m_code[k]; e_pc[k] = m_pc[k]; end
      end else if (m_phase[k] == 0) begin
        m_phase[k] = 1; e_npc[k] = m_tgt[k];
      end else m_pend[k] = 0;
    end
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(k ? ib.BUSY : ia.BUSY), 32'(m_pend[k]));
      chk($sformatf("trap_en%0d", k), 32'(k ? ib.TRAP_EN : ia.TRAP_EN), 32'(m_pend[k] && m_phase[k] == 0));
      chk($sformatf("flush%0d", k), 32'(k ? ib.FLUSH : ia.FLUSH), 32'(m_pend[k] && m_phase[k] == 1));
      chk($sformatf("trap_code%0d", k), k ? ib.TRAP_CODE : ia.TRAP_CODE, e_code[k]);
      chk($sformatf("trap_pc%0d", k), k ? ib.TRAP_PC : ia.TRAP_PC, e_pc[k]);
      chk($sformatf("new_pc%0d", k), k ? ib.NEW_PC : ia.NEW_PC, e_npc[k]);
    end
  endtask
  initial begin
    RST = 1; ia.MEM_WAIT = 0; ia.EXC_EN = 0; ia.EXC_CODE = 0; ia.EXC_PC = 0;
    ia.INT_EXT = 0; ia.INT_SOFT = 0; ia.INT_TIMER = 0; ia.INT_PC = 0; ia.INT_ALLOW = 0;
    ia.TRAP_VEC_MODE = 0; ia.TRAP_VEC_BASE = 0;
    #1; cyc(); cyc();
    chk("rst_busy", 32'(ia.BUSY), 0); chk("rst_code", ia.TRAP_CODE, 0); chk("rst_npc", ia.NEW_PC, 0);
    RST = 0;
    ia.TRAP_VEC_BASE = 32'h8000; ia.EXC_EN = 1; ia.EXC_CODE = 2; ia.EXC_PC = 32'h100;
    cyc(); ia.EXC_EN = 0;
    chk("exc_en", 32'(ia.TRAP_EN), 1); chk("exc_code", ia.TRAP_CODE, 2); chk("exc_pc", ia.TRAP_PC, 32'h100);
    cyc();
    chk("exc_flush", 32'(ia.FLUSH), 1); chk("exc_npc", ia.NEW_PC, 32'h8000); chk("exc_en_low", 32'(ia.TRAP_EN), 0);
    cyc();
    chk("exc_idle", 32'(ia.BUSY), 0);
    ia.INT_TIMER = 1; ia.INT_ALLOW = 1; ia.TRAP_VEC_MODE = 1; ia.INT_PC = 32'h204;
    cyc(); ia.INT_ALLOW = 0;
    chk("tmr_code", ia.TRAP_CODE, 32'h8000_0007); chk("tmr_pc", ia.TRAP_PC, 32'h204);
    cyc();
    chk("tmr_npc", ia.NEW_PC, 32'h801C);
    cyc(); ia.INT_TIMER = 0;
    ia.INT_EXT = 1; ia.INT_SOFT = 1; ia.INT_TIMER = 1; ia.INT_ALLOW = 1; ia.EXC_EN = 1; ia.EXC_CODE = 5;
    cyc(); ia.EXC_EN = 0; ia.INT_ALLOW = 0;
    chk("prio1_code", ia.TRAP_CODE, 5); chk("prio0_code", ib.TRAP_CODE, 32'h8000_000B);
    cyc();
    chk("prio1_npc", ia.NEW_PC, 32'h8000); chk("prio0_npc", ib.NEW_PC, 32'h802C);
    cyc(); ia.INT_SOFT = 0; ia.INT_TIMER = 0;
    for (int i = 0; i < 10; i++) cyc();
    chk("masked_busy", 32'(ia.BUSY), 0);
    ia.INT_ALLOW = 1;
    cyc(); ia.INT_ALLOW = 0;
    chk("unmask_en", 32'(ia.TRAP_EN), 1);
    cyc(); cyc(); ia.INT_EXT = 0;
    ia.MEM_WAIT = 1; ia.EXC_EN = 1; ia.EXC_CODE = 4; ia.EXC_PC = 32'h300; ia.TRAP_VEC_MODE = 0;
    cyc(); ia.EXC_CODE = 9; ia.EXC_PC = 32'h400;
    chk("wm_busy", 32'(ia.BUSY), 1); chk("wm_en", 32'(ia.TRAP_EN), 0);
    cyc(); ia.EXC_EN = 0;
    cyc(); cyc();
    chk("wm_hold_en", 32'(ia.TRAP_EN), 0);
    ia.MEM_WAIT = 0;
    cyc();
    chk("wm_commit", 32'(ia.TRAP_EN), 1); chk("wm_code", ia.TRAP_CODE, 4); chk("wm_pc", ia.TRAP_PC, 32'h300);
    cyc(); cyc();
    ia.MEM_WAIT = 1; ia.EXC_EN = 1;
    cyc(); ia.EXC_EN = 0; RST = 1;
    cyc(); RST = 0; ia.MEM_WAIT = 0;
    chk("rstw_busy", 32'(ia.BUSY), 0); chk("rstw_code", ia.TRAP_CODE, 0);
    cyc();
    chk("rstw_flush", 32'(ia.FLUSH), 0);
    ia.EXC_EN = 1; ia.EXC_CODE = 3;
    cyc(); ia.EXC_EN = 0; RST = 1;
    cyc(); RST = 0;
    chk("rstc_en", 32'(ia.TRAP_EN), 0); chk("rstc_busy", 32'(ia.BUSY), 0);
    cyc();
    chk("rstc_flush", 32'(ia.FLUSH), 0);
    ia.TRAP_VEC_BASE = 32'hFFFF_FFF0; ia.TRAP_VEC_MODE = 1; ia.INT_EXT = 1; ia.INT_ALLOW = 1;
    cyc(); ia.INT_ALLOW = 0; ia.INT_EXT = 0;
    cyc();
    chk("wrap_npc", ia.NEW_PC, 32'h0000_001C); chk("wrap_npc_b", ib.NEW_PC, 32'h0000_001C);
    cyc();
    for (int i = 0; i < 400; i++) begin
      RST              = ($urandom_range(39) == 0);
      ia.MEM_WAIT      = ($urandom_range(2) == 0);
      ia.EXC_EN        = ($urandom_range(3) == 0);
      ia.EXC_CODE      = $urandom;
      ia.EXC_PC        = $urandom;
      ia.INT_EXT       = ($urandom_range(4) == 0);
      ia.INT_SOFT      = ($urandom_range(4) == 0);
      ia.INT_TIMER     = ($urandom_range(4) == 0);
      ia.INT_PC        = $urandom;
      ia.INT_ALLOW     = ($urandom_range(1) == 0);
      ia.TRAP_VEC_MODE = 2'($urandom_range(3));
      ia.TRAP_VEC_BASE = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
